uart_tx_parity: RTL

Serial UART transmitter with optional even/odd parity, the transmit-side counterpart of the team's oversampling UART receiver. It accepts bytes over a valid/ready handshake into a one-entry holding register. It serialises each byte LSB-first as start, data, optional parity and stop bits, and times every bit in `tick_i` pulses from the shared baud tick generator. It sits between the system-side byte producer and the `txd` pin.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_hold.sv | 39 +++
 rtl/uart_tx_parity.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity helpers.
// TX_BREAK/TX_BRK_STOP exist only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_START    = 3'd1,
        TX_DATA     = 3'd2,
        TX_PARITY   = 3'd3,
        TX_STOP     = 3'd4
`ifdef UART_TX_BREAK_EN
        ,
        TX_BREAK    = 3'd5,
        TX_BRK_STOP = 3'd6
`endif
    } tx_state_t;

    localparam logic EVEN_PAR = 1'b0;
    localparam logic ODD_PAR  = 1'b1;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [7:0] data, input logic mode);
        return (mode == ODD_PAR) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry valid/ready holding register in front of the UART transmit shifter.
module uart_tx_hold
    import uart_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] in_data_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic         pop,
    output logic         full,
    output logic [W-1:0] data
);

    logic         r_full;
    logic [W-1:0] r_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            if (pop) begin
                r_full <= 1'b0;
            end
            if (in_vld_i && !r_full) begin
                r_full <= 1'b1;
                r_data <= in_data_i;
            end
        end
    end

    assign in_rdy_o = ~r_full;
    assign full     = r_full;
    assign data     = r_data;

endmodule

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits, timed by tick_i.
// Define UART_TX_BREAK_EN to add the break_i input and the line-break states.
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE_RATE = 16,
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned PARITY_ON       = 1,
    parameter int unsigned PARITY_EO       = 1,
    parameter int unsigned STOP_BITS       = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_i,
`endif
    input  logic                 tick_i,
    input  logic [DATA_BITS-1:0] txd_byte_i,
    input  logic                 txd_vld_i,
    output logic                 txd_rdy_o,
    output logic                 txd_o,
    output logic                 txd_busy_o,
    output logic [2:0]           fsm_state_tx
);

    localparam int unsigned    CW       = $clog2(OVERSAMPLE_RATE);
    localparam logic [CW-1:0]  CNT_LAST = CW'(OVERSAMPLE_RATE - 1);
`ifdef UART_TX_BREAK_EN
    localparam int unsigned    FRAME_TICKS = (1 + DATA_BITS + PARITY_ON + STOP_BITS) * OVERSAMPLE_RATE;
    localparam int unsigned    BW          = $clog2(FRAME_TICKS + 1);
    localparam logic [BW-1:0]  BRK_MIN     = BW'(FRAME_TICKS);
    logic [BW-1:0]             r_brk_cnt;
`endif

    tx_state_t              r_state;
    logic [CW-1:0]          r_tick_cnt;
    logic [2:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_txd;

    logic                   w_full;
    logic [DATA_BITS-1:0]   w_data;
    logic                   w_bit_end;
    logic                   w_last_stop;
    logic                   w_break;
    logic                   w_pop;

`ifdef UART_TX_BREAK_EN
    assign w_break = break_i;
`else
    assign w_break = 1'b0;
`endif

    assign w_bit_end   = tick_i && (r_tick_cnt == CNT_LAST);
    assign w_last_stop = (r_state == TX_STOP) && w_bit_end && (r_bit_cnt == 3'(STOP_BITS - 1));
    // Break outranks a pending byte, which simply stays in the holding register.
    assign w_pop       = w_full && !w_break && ((r_state == TX_IDLE) || w_last_stop);

    uart_tx_hold #(.W(DATA_BITS)) u_hold (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_data_i (txd_byte_i),
        .in_vld_i  (txd_vld_i),
        .in_rdy_o  (txd_rdy_o),
        .pop       (w_pop),
        .full      (w_full),
        .data      (w_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= TX_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_txd      <= 1'b1;
`ifdef UART_TX_BREAK_EN
            r_brk_cnt  <= '0;
`endif
        end else begin
            if (r_state != TX_IDLE && tick_i) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            case (r_state)
                TX_IDLE: begin
                    r_tick_cnt <= '0;
                    r_txd      <= 1'b1;
                    if (w_pop) begin
                        r_state <= TX_START;
                        r_txd   <= 1'b0;
                    end
`ifdef UART_TX_BREAK_EN
                    if (w_break) begin
                        r_state   <= TX_BREAK;
                        r_txd     <= 1'b0;
                        r_brk_cnt <= '0;
                    end
`endif
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_state   <= TX_DATA;
                        r_txd     <= r_shift[0];
                        r_bit_cnt <= '0;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            if (PARITY_ON != 0) begin
                                r_state <= TX_PARITY;
                                r_txd   <= r_par;
                            end else begin
                                r_state <= TX_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_txd     <= r_shift[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (w_bit_end) begin
                        r_state   <= TX_STOP;
                        r_txd     <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        if (!w_last_stop) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end else begin
                            r_bit_cnt <= '0;
                            r_state   <= TX_IDLE;
                            r_txd     <= 1'b1;
                            if (w_pop) begin
                                r_state <= TX_START;
                                r_txd   <= 1'b0;
                            end
`ifdef UART_TX_BREAK_EN
                            if (w_break) begin
                                r_state   <= TX_BREAK;
                                r_txd     <= 1'b0;
                                r_brk_cnt <= '0;
                            end
`endif
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                TX_BREAK: begin
                    if (tick_i && r_brk_cnt != BRK_MIN) begin
                        r_brk_cnt <= r_brk_cnt + 1'b1;
                    end
                    if (!w_break && r_brk_cnt == BRK_MIN) begin
                        r_state    <= TX_BRK_STOP;
                        r_txd      <= 1'b1;
                        r_tick_cnt <= '0;
                    end
                end
                TX_BRK_STOP: begin
                    if (w_bit_end) begin
                        r_state <= TX_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= TX_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
            if (w_pop) begin
                r_shift    <= w_data;
                r_par      <= parity_bit(8'(w_data), PARITY_EO != 0);
                r_tick_cnt <= '0;
            end
        end
    end

    assign txd_o        = r_txd;
    assign txd_busy_o   = (r_state != TX_IDLE) || w_full;
    assign fsm_state_tx = r_state;

endmodule
